// File: rtl/vga_pkg.sv
// Shared types for the VGA timing generator: pixel colour, per-axis timing set
// and the four-phase axis state.
package vga_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } axis_state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic [10:0] act;
        logic [7:0]  fp;
        logic [7:0]  sync;
        logic [7:0]  bp;
    } vga_timing_t;

    function automatic axis_state_t next_state(input axis_state_t s);
        case (s)
            ACTIVE:  return FP;
            FP:      return SYNC;
            SYNC:    return BP;
            default: return ACTIVE;
        endcase
    endfunction

    // A zero-length phase would never terminate, so zero widths become one.
    function automatic vga_timing_t fix_timing(input vga_timing_t t);
        vga_timing_t f;
        f = t;
        if (t.act == '0)  f.act  = 11'd1;
        if (t.fp == '0)   f.fp   = 8'd1;
        if (t.sync == '0) f.sync = 8'd1;
        if (t.bp == '0)   f.bp   = 8'd1;
        return f;
    endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// One display axis: ACTIVE -> FP -> SYNC -> BP phase machine with a phase-local
// counter that steps on 'advance'; 'wrap' marks the last step of BP.
module vga_axis_timer
    import vga_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        advance,
    input  logic [10:0] act_len,
    input  logic [7:0]  fp_len,
    input  logic [7:0]  sync_len,
    input  logic [7:0]  bp_len,
    output logic [1:0]  state,
    output logic        at_start,
    output logic        wrap
);

    axis_state_t state_q, state_d;
    logic [10:0] count_q, count_d;
    logic [10:0] cur_len;
    logic        last;

    always_comb begin
        case (state_q)
            ACTIVE:  cur_len = act_len;
            FP:      cur_len = {3'b000, fp_len};
            SYNC:    cur_len = {3'b000, sync_len};
            default: cur_len = {3'b000, bp_len};
        endcase
        last = (count_q == cur_len - 11'd1);

        state_d = state_q;
        count_d = count_q;
        wrap    = 1'b0;
        // Stopped: park at the first active position so a restart begins a frame.
        if (!run) begin
            state_d = ACTIVE;
            count_d = '0;
        end else if (advance) begin
            if (last) begin
                count_d = '0;
                state_d = next_state(state_q);
                wrap    = (state_q == BP);
            end else begin
                count_d = count_q + 11'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACTIVE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign state    = state_q;
    assign at_start = (state_q == ACTIVE) && (count_q == '0);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis timers, a shadowed timing
// set swapped in at the frame boundary, and a registered pixel/sync output stage.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int HOR_ACT   = 640,
    parameter int HOR_FP    = 16,
    parameter int HOR_SYNC  = 96,
    parameter int HOR_BP    = 48,
    parameter int VERT_ACT  = 480,
    parameter int VERT_FP   = 11,
    parameter int VERT_SYNC = 2,
    parameter int VERT_BP   = 31
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [23:0] pix_data,
    input  logic        pix_valid,
    input  logic        pix_sof,
    output logic        pix_ready,
    input  logic        cfg_we,
    input  logic [10:0] cfg_h_act,
    input  logic [10:0] cfg_v_act,
    input  logic [7:0]  cfg_hfp,
    input  logic [7:0]  cfg_hsync,
    input  logic [7:0]  cfg_hbp,
    input  logic [7:0]  cfg_vfp,
    input  logic [7:0]  cfg_vsync,
    input  logic [7:0]  cfg_vbp,
    output logic [7:0]  r,
    output logic [7:0]  g,
    output logic [7:0]  b,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start,
    output logic        underflow,
    output logic        sof_err
);

    localparam vga_timing_t H_DEFAULT = '{act: 11'(HOR_ACT), fp: 8'(HOR_FP),
                                          sync: 8'(HOR_SYNC), bp: 8'(HOR_BP)};
    localparam vga_timing_t V_DEFAULT = '{act: 11'(VERT_ACT), fp: 8'(VERT_FP),
                                          sync: 8'(VERT_SYNC), bp: 8'(VERT_BP)};

    vga_timing_t h_live_q, h_live_d, v_live_q, v_live_d;
    vga_timing_t h_shadow_q, h_shadow_d, v_shadow_q, v_shadow_d;
    rgb_t        rgb_q, rgb_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        frame_start_q, frame_start_d;
    logic        underflow_q, underflow_d, sof_err_q, sof_err_d;

    logic [1:0]  h_state, v_state;
    logic        h_at_start, v_at_start, h_wrap, v_wrap;
    logic        de, at_origin, xfer;

    vga_axis_timer u_h_timer (
        .clk      (pixel_clk),
        .rst      (rst),
        .run      (enable),
        .advance  (1'b1),
        .act_len  (h_live_q.act),
        .fp_len   (h_live_q.fp),
        .sync_len (h_live_q.sync),
        .bp_len   (h_live_q.bp),
        .state    (h_state),
        .at_start (h_at_start),
        .wrap     (h_wrap)
    );

    vga_axis_timer u_v_timer (
        .clk      (pixel_clk),
        .rst      (rst),
        .run      (enable),
        .advance  (h_wrap),
        .act_len  (v_live_q.act),
        .fp_len   (v_live_q.fp),
        .sync_len (v_live_q.sync),
        .bp_len   (v_live_q.bp),
        .state    (v_state),
        .at_start (v_at_start),
        .wrap     (v_wrap)
    );

    // Handshake: pix_ready is high in every active, enabled cycle whether or not
    // a pixel is offered; a pixel moves when pix_ready && pix_valid, and the
    // timing never stalls waiting for one.
    assign de        = (h_state == ACTIVE) && (v_state == ACTIVE);
    assign at_origin = h_at_start && v_at_start;
    assign pix_ready = de && enable && !rst;
    assign xfer      = pix_ready && pix_valid;

    always_comb begin
        h_live_d   = h_live_q;
        v_live_d   = v_live_q;
        h_shadow_d = h_shadow_q;
        v_shadow_d = v_shadow_q;

        if (cfg_we) begin
            h_shadow_d = fix_timing('{act: cfg_h_act, fp: cfg_hfp,
                                      sync: cfg_hsync, bp: cfg_hbp});
            v_shadow_d = fix_timing('{act: cfg_v_act, fp: cfg_vfp,
                                      sync: cfg_vsync, bp: cfg_vbp});
        end
        // v_wrap is the last cycle of the frame: swap here so no frame mixes sets.
        if (v_wrap) begin
            h_live_d = h_shadow_q;
            v_live_d = v_shadow_q;
        end

        rgb_d         = xfer ? rgb_t'(pix_data) : '0;
        hsync_d       = !(enable && (h_state == SYNC));
        vsync_d       = !(enable && (v_state == SYNC));
        frame_start_d = pix_ready && at_origin;
        underflow_d   = underflow_q || (pix_ready && !pix_valid);
        sof_err_d     = sof_err_q || (xfer && (at_origin != pix_sof));
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            h_live_q      <= H_DEFAULT;
            v_live_q      <= V_DEFAULT;
            h_shadow_q    <= H_DEFAULT;
            v_shadow_q    <= V_DEFAULT;
            rgb_q         <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            frame_start_q <= 1'b0;
            underflow_q   <= 1'b0;
            sof_err_q     <= 1'b0;
        end else begin
            h_live_q      <= h_live_d;
            v_live_q      <= v_live_d;
            h_shadow_q    <= h_shadow_d;
            v_shadow_q    <= v_shadow_d;
            rgb_q         <= rgb_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            frame_start_q <= frame_start_d;
            underflow_q   <= underflow_d;
            sof_err_q     <= sof_err_d;
        end
    end

    assign r           = rgb_q.r;
    assign g           = rgb_q.g;
    assign b           = rgb_q.b;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = frame_start_q;
    assign underflow   = underflow_q;
    assign sof_err     = sof_err_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: every cycle is checked against a frame-position
// model (cycle index within the frame -> x/y by division), plus directed cases.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 1;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;

    logic        clk = 1'b0;
    logic        rst, enable, pix_valid, pix_sof, pix_ready, cfg_we;
    logic [23:0] pix_data;
    logic [10:0] cfg_h_act, cfg_v_act;
    logic [7:0]  cfg_hfp, cfg_hsync, cfg_hbp, cfg_vfp, cfg_vsync, cfg_vbp;
    logic [7:0]  r, g, b;
    logic        hsync, vsync, frame_start, underflow, sof_err;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .HOR_ACT(HA), .HOR_FP(HF), .HOR_SYNC(HS), .HOR_BP(HB),
        .VERT_ACT(VA), .VERT_FP(VF), .VERT_SYNC(VS), .VERT_BP(VB)
    ) dut (
        .pixel_clk(clk), .rst(rst), .enable(enable),
        .pix_data(pix_data), .pix_valid(pix_valid), .pix_sof(pix_sof),
        .pix_ready(pix_ready), .cfg_we(cfg_we),
        .cfg_h_act(cfg_h_act), .cfg_v_act(cfg_v_act),
        .cfg_hfp(cfg_hfp), .cfg_hsync(cfg_hsync), .cfg_hbp(cfg_hbp),
        .cfg_vfp(cfg_vfp), .cfg_vsync(cfg_vsync), .cfg_vbp(cfg_vbp),
        .r(r), .g(g), .b(b), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .underflow(underflow), .sof_err(sof_err)
    );

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        int exp_frame, exp_hs_low, exp_vs_low;
    } cfg_vec_t;

    cfg_vec_t vecs[4];

    int total = 0;
    int bad   = 0;

    // model: live/shadow timing as {ha,hf,hs,hb,va,vf,vs,vb}, cycle index in frame
    int live[8];
    int shadow[8];
    int m_t;
    bit m_uf, m_se;
    int dut_xfers, fs_cnt, hs_low, vs_low;
    logic [23:0] pix_ctr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int fixw(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int line_len();
        return live[0] + live[1] + live[2] + live[3];
    endfunction

    function automatic int frame_len();
        return line_len() * (live[4] + live[5] + live[6] + live[7]);
    endfunction

    // Called just after a negedge with inputs already driven.
    task automatic tick();
        int x, y, ll;
        bit de, rdy, xf, hs_in, vs_in, e_hs, e_vs, e_fs, boundary;
        logic [23:0] e_rgb;
        #1;
        if (rst) begin
            rdy = 0; xf = 0; e_rgb = '0; e_hs = 1; e_vs = 1; e_fs = 0;
            m_uf = 0; m_se = 0;
        end else begin
            ll    = line_len();
            x     = m_t % ll;
            y     = m_t / ll;
            de    = (x < live[0]) && (y < live[4]);
            rdy   = de && enable;
            xf    = rdy && pix_valid;
            e_rgb = xf ? pix_data : 24'h0;
            hs_in = (x >= live[0] + live[1]) && (x < live[0] + live[1] + live[2]);
            vs_in = (y >= live[4] + live[5]) && (y < live[4] + live[5] + live[6]);
            e_hs  = !(enable && hs_in);
            e_vs  = !(enable && vs_in);
            e_fs  = rdy && (m_t == 0);
            if (rdy && !pix_valid) m_uf = 1;
            if (xf && ((m_t == 0) != pix_sof)) m_se = 1;
        end
        chk("pix_ready", pix_ready, rdy);
        if (pix_ready && pix_valid) dut_xfers++;

        if (rst) begin
            live   = '{HA, HF, HS, HB, VA, VF, VS, VB};
            shadow = '{HA, HF, HS, HB, VA, VF, VS, VB};
            m_t    = 0;
        end else begin
            boundary = enable && (m_t == frame_len() - 1);
            if (boundary) begin
                live = shadow;
                m_t  = 0;
            end else if (enable) begin
                m_t++;
            end else begin
                m_t = 0;
            end
            if (cfg_we)
                shadow = '{fixw(cfg_h_act), fixw(cfg_hfp), fixw(cfg_hsync), fixw(cfg_hbp),
                           fixw(cfg_v_act), fixw(cfg_vfp), fixw(cfg_vsync), fixw(cfg_vbp)};
        end

        @(posedge clk);
        #1;
        chk("rgb", {r, g, b}, e_rgb);
        chk("hsync", hsync, e_hs);
        chk("vsync", vsync, e_vs);
        chk("frame_start", frame_start, e_fs);
        chk("underflow", underflow, m_uf);
        chk("sof_err", sof_err, m_se);
        if (frame_start) fs_cnt++;
        if (!hsync) hs_low++;
        if (!vsync) vs_low++;
        @(negedge clk);
    endtask

    // Driver: well-formed pixel stream with sof on the frame origin.
    task automatic px_tick();
        pix_valid = 1'b1;
        pix_sof   = (m_t == 0);
        pix_data  = pix_ctr;
        pix_ctr   = pix_ctr + 24'd1;
        tick();
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    task automatic set_cfg(input int ha, hf, hs, hb, va, vf, vs, vb);
        cfg_h_act = 11'(ha); cfg_hfp = 8'(hf); cfg_hsync = 8'(hs); cfg_hbp = 8'(hb);
        cfg_v_act = 11'(va); cfg_vfp = 8'(vf); cfg_vsync = 8'(vs); cfg_vbp = 8'(vb);
    endtask

    initial begin
        int cnt, len, hacc, vacc;

        vecs[0] = '{8, 2, 3, 1, 4, 1, 2, 1, 112, 24, 28};
        vecs[1] = '{4, 2, 3, 1, 4, 1, 2, 1, 80, 24, 20};
        vecs[2] = '{0, 0, 0, 0, 0, 0, 0, 0, 16, 4, 4};
        vecs[3] = '{3, 1, 1, 1, 2, 1, 1, 1, 30, 5, 6};

        rst = 1'b1; enable = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        pix_data = '0; cfg_we = 1'b0; pix_ctr = 24'h000100;
        set_cfg(0, 0, 0, 0, 0, 0, 0, 0);
        live = '{HA, HF, HS, HB, VA, VF, VS, VB};
        shadow = live;
        m_t = 0; m_uf = 0; m_se = 0;
        dut_xfers = 0; fs_cnt = 0; hs_low = 0; vs_low = 0;
        @(negedge clk);
        do_reset(2);
        chk("reset_hsync", hsync, 1'b1);
        chk("reset_vsync", vsync, 1'b1);
        chk("reset_rgb", {r, g, b}, 24'h0);
        chk("reset_flags", {underflow, sof_err, frame_start}, 3'b000);

        // Two whole frames with a constant pixel stream.
        enable = 1'b1;
        dut_xfers = 0; fs_cnt = 0; hs_low = 0; vs_low = 0;
        for (int i = 0; i < 112; i++) px_tick();
        chk("xfers_per_frame", dut_xfers, 32);
        chk("fs_per_frame", fs_cnt, 1);
        chk("hsync_low_per_frame", hs_low, 24);
        chk("vsync_low_per_frame", vs_low, 28);
        for (int i = 0; i < 112; i++) px_tick();
        chk("fs_two_frames", fs_cnt, 2);
        chk("underflow_clean", underflow, 1'b0);

        // Drop one pixel: x=5 on line 2 is frame cycle 2*14+5.
        for (int i = 0; i < 112; i++) begin
            if (m_t == 33) begin
                pix_valid = 1'b0; pix_sof = 1'b0; pix_data = 24'hABCDEF;
                tick();
                chk("drop_rgb_zero", {r, g, b}, 24'h0);
                chk("drop_underflow", underflow, 1'b1);
            end else begin
                px_tick();
            end
        end
        for (int i = 0; i < 40; i++) px_tick();
        chk("underflow_sticky", underflow, 1'b1);

        // Reset mid-line, then a first pixel without sof.
        for (int i = 0; i < 17; i++) px_tick();
        do_reset(1);
        chk("midline_rst_flags", {underflow, sof_err}, 2'b00);
        chk("midline_rst_syncs", {hsync, vsync}, 2'b11);
        pix_valid = 1'b1; pix_sof = 1'b0; pix_data = 24'h123456;
        tick();
        chk("sof_err_first_pixel", sof_err, 1'b1);
        chk("first_pixel_shown", {r, g, b}, 24'h123456);

        // Enable gap from cycle 50 to 59.
        do_reset(1);
        for (int c = 0; c < 150; c++) begin
            enable = !(c >= 50 && c < 60);
            px_tick();
            if (c == 55) begin
                chk("gap_syncs", {hsync, vsync}, 2'b11);
                chk("gap_rgb", {r, g, b}, 24'h0);
            end
            if (c == 60) chk("fs_after_gap", frame_start, 1'b1);
        end

        // Random traffic, config writes, enable toggles and resets.
        enable = 1'b1;
        for (int i = 0; i < 2500; i++) begin
            rst       = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 99) == 0) enable = !enable;
            pix_valid = ($urandom_range(0, 9) != 0);
            pix_sof   = (m_t == 0) ^ ($urandom_range(0, 59) == 0);
            pix_data  = 24'($urandom);
            cfg_we    = ($urandom_range(0, 149) == 0);
            set_cfg($urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            tick();
        end
        rst = 1'b0; cfg_we = 1'b0;

        // Table: each timing set takes effect on the frame after its write.
        do_reset(1);
        enable = 1'b1;
        for (int v = 0; v < 4; v++) begin
            if (m_t == frame_len() - 1) px_tick();
            set_cfg(vecs[v].ha, vecs[v].hf, vecs[v].hs, vecs[v].hb,
                    vecs[v].va, vecs[v].vf, vecs[v].vs, vecs[v].vb);
            cfg_we = 1'b1;
            px_tick();
            cfg_we = 1'b0;
            cnt = 0;
            do begin
                px_tick();
                cnt++;
            end while (!frame_start && cnt < 2000);
            chk("table_fs_seen", frame_start, 1'b1);
            len = 1; hacc = !hsync; vacc = !vsync; cnt = 0;
            forever begin
                px_tick();
                cnt++;
                if (frame_start || cnt >= 2000) break;
                len++;
                hacc += !hsync;
                vacc += !vsync;
            end
            chk("table_frame_len", len, vecs[v].exp_frame);
            chk("table_hsync_low", hacc, vecs[v].exp_hs_low);
            chk("table_vsync_low", vacc, vecs[v].exp_vs_low);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
